// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared FSM state encoding for the timer_ctrl block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Busy covers the load cycle and the counting phase of a run.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_RUN);
    endfunction

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module      : timer_ctrl
// Description : Load/run/terminal timer with one-shot or auto-reload modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_ctrl
    import timer_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           stop,
    input  logic           periodic,
    input  logic [LEN-1:0] load_val,
    input  logic [LEN-1:0] term_val,
    output logic [LEN-1:0] count,
    output logic           busy,
    output logic           tick,
    output logic           done
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [LEN-1:0] r_count;
    logic [LEN-1:0] w_count_nxt;
    logic           w_at_term;

    assign w_at_term = (r_count == term_val);

    // Stop suppresses the terminal strobe in the same cycle it aborts the run.
    assign tick  = (r_state == ST_RUN) && w_at_term && !stop;
    assign busy  = state_is_busy(r_state);
    assign done  = (r_state == ST_DONE);
    assign count = r_count;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_count_nxt = load_val;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_at_term) begin
                    // Count holds at the terminal value through LOAD or DONE.
                    w_state_nxt = periodic ? ST_LOAD : ST_DONE;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule : timer_ctrl

`default_nettype wire

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: LEN, default 4, width of count, load and terminal values.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin a timing run (level-sampled each edge).
REQ-005 stop  input  1  abort the current run.
REQ-006 periodic  input  1  1 = auto-reload after terminal, 0 = one-shot; sampled at terminal.
REQ-007 load_val  input  LEN  start value loaded into the count register.
REQ-008 term_val  input  LEN  terminal value compared against count.
REQ-009 count  output  LEN  current count register value.
REQ-010 busy  output  1  high in LOAD and RUN.
REQ-011 tick  output  1  one-cycle terminal strobe.
REQ-012 done  output  1  one-cycle completion strobe after a one-shot run.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: count SHALL hold; start=1 at an edge SHALL move to LOAD.
REQ-015 LOAD: count SHALL become load_val at the closing edge; next state RUN (lasts exactly 1 cycle).
REQ-016 RUN: count SHALL increment by 1 per cycle, modulo 2^LEN (15 -> 0 for LEN=4).
REQ-017 tick SHALL be combinational: state==RUN and count==term_val and stop==0.
REQ-018 On tick: periodic=1 -> LOAD (count holds term_val during LOAD); periodic=0 -> DONE (count holds).
REQ-019 DONE: done=1 for exactly that cycle, count holds, next state IDLE unconditionally.
REQ-020 stop=1 in LOAD or RUN SHALL force IDLE and count=0 at the next edge; stop has priority over terminal and reload; stop in IDLE/DONE ignored.
REQ-021 start while busy or in DONE SHALL be ignored; no queuing.
REQ-022 Latency: start sampled at edge k -> LOAD in cycle k+1, count==load_val first RUN cycle k+2.
REQ-023 Periodic period SHALL be ((term_val - load_val) mod 2^LEN) + 2 cycles between ticks.
REQ-024 load_val==term_val SHALL produce tick in the first RUN cycle.
REQ-025 load_val, term_val changes during RUN SHALL take effect immediately for term_val, next LOAD for load_val.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=IDLE and count=0, regardless of phase.
REQ-027 During and after reset: busy=0, tick=0, done=0 until a new start.
REQ-028 Release of reset SHALL not itself start a run; start must be sampled high after release.

Structure
REQ-029 State encoding SHALL live in shared package timer_pkg (2-bit state type, IDLE=0, LOAD=1, RUN=2, DONE=3).
REQ-030 count register SHALL be local to timer_ctrl with asynchronous reset; no sub-module instantiated.
REQ-031 Next-state/output logic SHALL be combinational; only state and count are registered.

Verification (LEN=4)
REQ-032 One-shot: load_val=3, term_val=6, periodic=0, start pulse -> count 3,4,5,6, tick at 6, done next cycle, then IDLE with count=6.
REQ-033 Periodic: load_val=2, term_val=4, periodic=1 -> tick every 4 cycles, busy stays 1, done never asserted.
REQ-034 Wrap: load_val=14, term_val=1 -> count 14,15,0,1, tick at 1.
REQ-035 Abort: stop=1 when count=6 and term_val=6 -> tick=0, next edge IDLE, count=0, done=0.
REQ-036 Async reset: reset_n low mid-RUN between edges -> count=0, busy=0 immediately, no edge needed.
REQ-037 Boundary: load_val=term_val=7 -> tick in first RUN cycle; start held high throughout run ignored until IDLE.
